// File: rtl/dec2to4_stream.sv
// Stream 2-to-4 decoder: decodes priority-encoder codes into one-hot vectors,
// buffers them in a 2-entry FIFO and keeps saturating per-output pop statistics.
module dec2to4_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       q,
  input  logic             v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       d,
  input  logic             clr_stats,
  input  logic [2:0]       stat_sel,
  output logic [CNT_W-1:0] stat_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [3:0]       dec_s;
  logic [3:0]       head_r;
  logic [3:0]       tail_r;
  logic [CNT_W-1:0] hit_cnt_r [4];
  logic [CNT_W-1:0] null_cnt_r;
  logic [CNT_W-1:0] stat_cnt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + CNT_W'(1'b1);
    end
  endfunction

  assign push_s    = in_valid && in_ready_s;
  assign pop_s     = out_valid_s && out_ready;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign d         = head_r;
  assign stat_cnt  = stat_cnt_s;

  // Decode the incoming code; q is meaningless when v is low.
  always_comb begin
    dec_s = 4'b0000;
    if (v) begin
      dec_s = 4'b0001 << q;
    end else begin
      dec_s = 4'b0000;
    end
  end

  // FSM state register: occupancy of the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) state_nxt_s = ST_ONE;
        else        state_nxt_s = ST_EMPTY;
      end
      ST_ONE: begin
        if (push_s && !pop_s)      state_nxt_s = ST_FULL;
        else if (pop_s && !push_s) state_nxt_s = ST_EMPTY;
        else                       state_nxt_s = ST_ONE;
      end
      ST_FULL: begin
        if (pop_s) state_nxt_s = ST_ONE;
        else       state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // FSM outputs; FULL never accepts, even while popping, so there is no bypass.
  always_comb begin
    in_ready_s  = 1'b1;
    out_valid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_ONE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b1;
      end
      ST_FULL: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // FIFO storage; vacated slots are zeroed so d reads 0000 whenever EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= 4'b0000;
      tail_r <= 4'b0000;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) head_r <= dec_s;
        end
        ST_ONE: begin
          if (push_s && pop_s) head_r <= dec_s;
          else if (push_s)     tail_r <= dec_s;
          else if (pop_s)      head_r <= 4'b0000;
        end
        ST_FULL: begin
          if (pop_s) begin
            head_r <= tail_r;
            tail_r <= 4'b0000;
          end
        end
        default: begin
          head_r <= 4'b0000;
          tail_r <= 4'b0000;
        end
      endcase
    end
  end

  // Pop statistics; a clear takes priority over the increment of the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hit_cnt_r[i] <= {CNT_W{1'b0}};
      null_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_stats) begin
      for (int i = 0; i < 4; i++) hit_cnt_r[i] <= {CNT_W{1'b0}};
      null_cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      if (head_r == 4'b0000) begin
        null_cnt_r <= sat_inc(null_cnt_r);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (head_r[i]) hit_cnt_r[i] <= sat_inc(hit_cnt_r[i]);
        end
      end
    end
  end

  // Statistics read mux.
  always_comb begin
    stat_cnt_s = {CNT_W{1'b0}};
    case (stat_sel)
      3'd0:    stat_cnt_s = hit_cnt_r[0];
      3'd1:    stat_cnt_s = hit_cnt_r[1];
      3'd2:    stat_cnt_s = hit_cnt_r[2];
      3'd3:    stat_cnt_s = hit_cnt_r[3];
      3'd4:    stat_cnt_s = null_cnt_r;
      default: stat_cnt_s = {CNT_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_dec2to4_stream.sv
// Self-checking bench for dec2to4_stream: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_dec2to4_stream;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       q;
  logic             v;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       d;
  logic             clr_stats;
  logic [2:0]       stat_sel;
  logic [CNT_W-1:0] stat_cnt;

  int checks;
  int errors;

  logic [3:0] fifo_m [$];
  int         hit_m [4];
  int         null_m;

  dec2to4_stream #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .clr_stats (clr_stats),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_stat(input logic [2:0] sel);
    if (sel < 3'd4)       return hit_m[sel];
    else if (sel == 3'd4) return null_m;
    else                  return 0;
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    for (int i = 0; i < 4; i++) hit_m[i] = 0;
    null_m = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(fifo_m.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
    chk("d", 32'(d), (fifo_m.size() > 0) ? 32'(fifo_m[0]) : 32'd0);
    chk("stat_cnt", 32'(stat_cnt), 32'(exp_stat(stat_sel)));
  endtask

  // One clock: check current outputs, then advance the model by the handshakes seen at the edge.
  task automatic cycle();
    bit         push;
    bit         pop;
    bit         clr;
    logic [3:0] entry;
    logic [3:0] popped;
    #1;
    check_outputs();
    push  = in_valid && (fifo_m.size() < 2);
    pop   = out_ready && (fifo_m.size() > 0);
    clr   = clr_stats;
    entry = v ? 4'(1 << q) : 4'd0;
    @(posedge clk);
    if (pop) begin
      popped = fifo_m.pop_front();
      if (popped == 4'd0) begin
        if (null_m < CMAX) null_m++;
      end else begin
        for (int i = 0; i < 4; i++)
          if (popped[i] && hit_m[i] < CMAX) hit_m[i]++;
      end
    end
    if (push) fifo_m.push_back(entry);
    if (clr) model_reset_counters();
    #1;
  endtask

  task automatic model_reset_counters();
    for (int i = 0; i < 4; i++) hit_m[i] = 0;
    null_m = 0;
  endtask

  task automatic set_in(input logic iv, input logic [1:0] qq, input logic vv, input logic ordy);
    in_valid  = iv;
    q         = qq;
    v         = vv;
    out_ready = ordy;
  endtask

  task automatic check_all_stats(input string tag);
    for (int s = 0; s < 8; s++) begin
      stat_sel = 3'(s);
      #1;
      chk(tag, 32'(stat_cnt), 32'(exp_stat(3'(s))));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    set_in(1'b0, 2'd0, 1'b0, 1'b0);
    clr_stats = 1'b0;
    stat_sel  = 3'd0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_all_stats("rst_stat");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Codes 0..3 streamed back-to-back with out_ready high; first push on the first edge.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'(i), 1'b1, 1'b1);
      cycle();
    end
    set_in(1'b0, 2'd0, 1'b0, 1'b1);
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      stat_sel = 3'(i);
      #1;
      chk("hit_after_stream", 32'(stat_cnt), 32'd1);
    end

    // Backpressure: fill to FULL, third code held.
    set_in(1'b1, 2'd2, 1'b1, 1'b0); cycle();
    set_in(1'b1, 2'd1, 1'b1, 1'b0); cycle();
    set_in(1'b1, 2'd3, 1'b1, 1'b0); cycle();
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(d), 32'h4);
    cycle();
    // FULL with in_valid and out_ready: only the pop, push on the next cycle.
    set_in(1'b1, 2'd3, 1'b1, 1'b1); cycle();
    #1;
    chk("no_bypass_head", 32'(d), 32'h2);
    chk("no_bypass_in_ready", 32'(in_ready), 32'd1);
    cycle();
    set_in(1'b0, 2'd0, 1'b0, 1'b1);
    cycle(); cycle(); cycle();

    // Null code: v=0 with q=3
    stat_sel = 3'd3;
    set_in(1'b1, 2'd3, 1'b0, 1'b0); cycle();
    #1;
    chk("null_d", 32'(d), 32'd0);
    chk("null_out_valid", 32'(out_valid), 32'd1);
    set_in(1'b0, 2'd0, 1'b0, 1'b1); cycle();
    chk("hit3_unchanged", 32'(stat_cnt), 32'd2);
    stat_sel = 3'd4;
    #1;
    chk("null_cnt", 32'(stat_cnt), 32'd1);

    // Saturation of hit_cnt[1], then clear during a pop.
    stat_sel = 3'd1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'd1, 1'b1, 1'b1);
      cycle();
    end
    set_in(1'b0, 2'd0, 1'b0, 1'b1);
    cycle();
    #1;
    chk("sat_hit1", 32'(stat_cnt), 32'd3);
    set_in(1'b1, 2'd1, 1'b1, 1'b1); cycle();
    set_in(1'b0, 2'd0, 1'b0, 1'b1);
    clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    #1;
    chk("clr_wins", 32'(stat_cnt), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 4) != 0),
             1'($urandom_range(0, 2) != 0));
      clr_stats = 1'($urandom_range(0, 40) == 0);
      stat_sel  = 3'($urandom);
      cycle();
    end
    clr_stats = 1'b0;

    // Asynchronous reset while FULL, mid-cycle.
    set_in(1'b1, 2'd0, 1'b1, 1'b0);
    cycle(); cycle(); cycle();
    #1;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    set_in(1'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_d", 32'(d), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    check_all_stats("async_rst_stat");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    set_in(1'b1, 2'd2, 1'b1, 1'b1);
    cycle();
    #1;
    chk("first_push_after_rst", 32'(d), 32'h4);
    set_in(1'b0, 2'd0, 1'b0, 1'b1);
    cycle();
    cycle();
    check_all_stats("final_stat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec2to4_stream.md
DEC2TO4_STREAM -- requirements
Module: dec2to4_stream

Interface
REQ-001 Parameter CNT_W, default 8: width of each statistics counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream has an encoded code on q/v.
REQ-005 in_ready  output  1  block can accept a code this cycle.
REQ-006 q  input  2  encoded index, the priority-encoder output format.
REQ-007 v  input  1  code-valid flag; 0 means "no line active".
REQ-008 out_valid  output  1  d holds a decoded entry.
REQ-009 out_ready  input  1  downstream accepts d this cycle.
REQ-010 d  output  4  one-hot decoded vector.
REQ-011 clr_stats  input  1  synchronous clear of all statistics counters.
REQ-012 stat_sel  input  3  statistics counter select.
REQ-013 stat_cnt  output  CNT_W  selected counter value.

Function
REQ-014 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-015 Decode at push: v=1 stores d = 4'b0001 << q; v=0 stores d = 4'b0000.
REQ-016 Storage is a 2-entry FIFO that preserves order.
REQ-017 FSM states: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
REQ-018 FSM transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE.
  - FULL: pop -> ONE.
REQ-019 in_ready = 1 in EMPTY and ONE, and 0 in FULL, including a FULL cycle with a simultaneous pop (no bypass).
REQ-020 out_valid = 1 in ONE and FULL, and 0 in EMPTY; d = head entry; d = 4'b0000 when EMPTY.
REQ-021 Latency: a code pushed at edge N is visible on d/out_valid after edge N; there is no combinational in->out path.
REQ-022 While out_valid=1 and out_ready=0, d and out_valid stay stable.
REQ-023 On each pop, the counter of the popped entry increments by 1:
  - hit_cnt[i] when d[i]=1.
  - null_cnt when d=0.
REQ-024 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-025 stat_cnt is combinational on stat_sel:
  - 0..3 -> hit_cnt[0..3].
  - 4 -> null_cnt.
  - 5..7 -> 0.
REQ-026 clr_stats=1 zeroes all counters at the next edge; clear wins over a simultaneous pop-increment.
REQ-027 q is ignored when v=0; inputs are ignored when in_valid=0.

Reset
REQ-028 rst_n=0 immediately, without waiting for a clock, forces:
  - FSM to EMPTY;
  - FIFO contents to 0;
  - all counters to 0.
  Resulting outputs: out_valid=0, d=4'b0000, in_ready=1, stat_cnt=0.
REQ-029 Reset mid-transfer discards buffered entries and does not count them.
REQ-030 After rst_n deasserts, the first push is accepted on the next rising edge.

Verification
REQ-031 Reset, out_ready=1, push q=0..3 with v=1 one per cycle -> d = 0001, 0010, 0100, 1000, each one cycle after its push; hit_cnt[0..3] = 1 each.
REQ-032 out_ready=0, push q=2 v=1, q=1 v=1, q=3 v=1 -> first two accepted, state FULL, in_ready=0, third held; with out_ready=1 -> d = 0100, then 0010, then 1000.
REQ-033 FULL with in_valid=1 and out_ready=1 in the same cycle -> only the pop occurs, state ONE; the push is accepted on the following cycle.
REQ-034 Push v=0 with q=3, then pop -> d = 0000 with out_valid=1; stat_sel=4 gives 1; hit_cnt[3] unchanged.
REQ-035 CNT_W=2: pop q=1 five times -> stat_sel=1 reads 3 (saturated); clr_stats pulsed together with a pop -> reads 0.
REQ-036 Assert rst_n=0 while FULL, mid-cycle -> out_valid=0 and d=0000 before the next edge; all counters read 0.
